// File: rtl/sprite_motion_ctrl.sv
// Maze sprite movement engine: persistent motion, queued turn, tunnel wrap, animation frame.
// Latency: 1 cycle from an accepted move_tick. No backpressure; freeze holds all state.
module sprite_motion_ctrl #(
    parameter int POS_W       = 10,
    parameter int STEP        = 2,
    parameter int X_INIT      = 360,
    parameter int Y_INIT      = 154,
    parameter int X_MIN       = 150,
    parameter int X_MAX       = 600,
    parameter int ANIM_DIV    = 4,
    parameter int ANIM_FRAMES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           move_tick,
    input  logic                           freeze,
    input  logic                           req_r,
    input  logic                           req_l,
    input  logic                           req_u,
    input  logic                           req_d,
    input  logic [3:0]                     leg,
    output logic [POS_W-1:0]               pos_x,
    output logic [POS_W-1:0]               pos_y,
    output logic [1:0]                     dir,
    output logic                           moving,
    output logic                           facing_left,
    output logic [$clog2(ANIM_FRAMES)-1:0] anim_frame,
    output logic                           wrap_pulse
);

    localparam int AW = $clog2(ANIM_FRAMES);
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MOVING  = 2'd1;
    localparam logic [1:0] BLOCKED = 2'd2;

    localparam logic [1:0] D_R = 2'd0;
    localparam logic [1:0] D_L = 2'd1;
    localparam logic [1:0] D_U = 2'd2;

    localparam logic [POS_W:0]   STEP_E  = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]   XMIN_E  = (POS_W+1)'(X_MIN);
    localparam logic [POS_W:0]   XMAX_E  = (POS_W+1)'(X_MAX);
    localparam logic [POS_W-1:0] STEP_P  = POS_W'(STEP);
    localparam logic [POS_W-1:0] XMIN_P  = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] XMAX_P  = POS_W'(X_MAX);
    localparam logic [CW-1:0]    CNT_TOP = CW'(ANIM_DIV - 1);
    localparam logic [AW-1:0]    FRM_TOP = AW'(ANIM_FRAMES - 1);

    logic [1:0]       state;
    logic             pend_valid;
    logic [1:0]       pend_dir;
    logic [CW-1:0]    anim_cnt;

    logic             tick;
    logic             any_req;
    logic [1:0]       req_dir;
    logic [1:0]       pend_dir_c;
    logic             pend_valid_c;
    logic             take_turn;
    logic [1:0]       dir_c;
    logic             go;
    logic [POS_W:0]   x_ext;
    logic [POS_W-1:0] next_x;
    logic [POS_W-1:0] next_y;
    logic             wrap_c;

    always_comb begin
        tick    = move_tick & ~freeze;
        any_req = req_r | req_l | req_u | req_d;
        if (req_r)      req_dir = 2'd0;
        else if (req_l) req_dir = 2'd1;
        else if (req_u) req_dir = 2'd2;
        else            req_dir = 2'd3;

        pend_dir_c   = any_req ? req_dir : pend_dir;
        pend_valid_c = any_req | pend_valid;
        take_turn    = pend_valid_c & leg[pend_dir_c];
        dir_c        = take_turn ? pend_dir_c : dir;
        // In IDLE a taken turn is by construction legal, so it also steps.
        go           = (state == IDLE) ? take_turn : leg[dir_c];
    end

    // Wrap tests use one extra bit so x - STEP near zero cannot alias.
    always_comb begin
        x_ext  = {1'b0, pos_x};
        next_x = pos_x;
        next_y = pos_y;
        wrap_c = 1'b0;
        case (dir_c)
            D_R: begin
                if (x_ext + STEP_E > XMAX_E) begin
                    next_x = XMIN_P;
                    wrap_c = 1'b1;
                end else begin
                    next_x = pos_x + STEP_P;
                end
            end
            D_L: begin
                if (x_ext < XMIN_E + STEP_E) begin
                    next_x = XMAX_P;
                    wrap_c = 1'b1;
                end else begin
                    next_x = pos_x - STEP_P;
                end
            end
            D_U:     next_y = pos_y - STEP_P;
            default: next_y = pos_y + STEP_P;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x       <= POS_W'(X_INIT);
            pos_y       <= POS_W'(Y_INIT);
            dir         <= D_R;
            moving      <= 1'b0;
            facing_left <= 1'b0;
            anim_frame  <= '0;
            wrap_pulse  <= 1'b0;
            state       <= IDLE;
            pend_valid  <= 1'b0;
            pend_dir    <= 2'd0;
            anim_cnt    <= '0;
        end else if (tick) begin
            pend_dir   <= pend_dir_c;
            pend_valid <= pend_valid_c & ~take_turn;
            dir        <= dir_c;
            if (take_turn && dir_c == D_L) facing_left <= 1'b1;
            if (take_turn && dir_c == D_R) facing_left <= 1'b0;
            moving     <= go;
            wrap_pulse <= go & wrap_c;
            if (go) begin
                pos_x <= next_x;
                pos_y <= next_y;
                state <= MOVING;
                if (anim_cnt == CNT_TOP) begin
                    anim_cnt   <= '0;
                    anim_frame <= (anim_frame == FRM_TOP) ? '0 : anim_frame + 1'b1;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end else if (state == MOVING) begin
                state <= BLOCKED;
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: a behavioural model queues expected outputs per cycle.
module tb_sprite_motion_ctrl;

    localparam int XMIN = 150;
    localparam int XMAX = 600;
    localparam int STP  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_tick = 1'b0, freeze = 1'b0;
    logic       req_r = 1'b0, req_l = 1'b0, req_u = 1'b0, req_d = 1'b0;
    logic [3:0] leg = 4'hF;
    logic [9:0] pos_x, pos_y;
    logic [1:0] dir;
    logic       moving, facing_left, wrap_pulse;
    logic [1:0] anim_frame;

    logic       o_tick = 1'b0, o_req_r = 1'b0, o_req_l = 1'b0;
    logic [9:0] o_pos_x, o_pos_y;
    logic [1:0] o_dir, o_anim_frame;
    logic       o_moving, o_facing_left, o_wrap_pulse;

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .move_tick(move_tick), .freeze(freeze),
        .req_r(req_r), .req_l(req_l), .req_u(req_u), .req_d(req_d), .leg(leg),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
        .facing_left(facing_left), .anim_frame(anim_frame), .wrap_pulse(wrap_pulse)
    );

    sprite_motion_ctrl #(.X_INIT(599)) u_odd (
        .clk(clk), .rst_n(rst_n), .move_tick(o_tick), .freeze(1'b0),
        .req_r(o_req_r), .req_l(o_req_l), .req_u(1'b0), .req_d(1'b0), .leg(4'hF),
        .pos_x(o_pos_x), .pos_y(o_pos_y), .dir(o_dir), .moving(o_moving),
        .facing_left(o_facing_left), .anim_frame(o_anim_frame), .wrap_pulse(o_wrap_pulse)
    );

    typedef struct {
        int x, y, d, mv, fl, fr, wp;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // model state
    int mx, my, md, mmv, mfl, mfr, mac, mst, mpv, mpd, mwp;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 360; my = 154; md = 0; mmv = 0; mfl = 0; mfr = 0;
        mac = 0; mst = 0; mpv = 0; mpd = 0; mwp = 0;
    endtask

    task automatic model_cycle(input bit mt, input bit fz, input bit r, input bit l,
                               input bit u, input bit d, input logic [3:0] lg);
        bit turned, adv;
        mwp = 0;
        if (mt && !fz) begin
            if (r || l || u || d) begin
                mpd = r ? 0 : (l ? 1 : (u ? 2 : 3));
                mpv = 1;
            end
            turned = 0;
            if (mpv == 1 && lg[mpd]) begin
                md = mpd; mpv = 0; turned = 1;
                if (md == 1) mfl = 1;
                if (md == 0) mfl = 0;
            end
            adv = (mst == 0) ? turned : lg[md];
            mmv = adv;
            if (adv) begin
                mst = 1;
                if (md == 0) begin
                    if (mx + STP > XMAX) begin mx = XMIN; mwp = 1; end
                    else mx = mx + STP;
                end else if (md == 1) begin
                    if (mx < XMIN + STP) begin mx = XMAX; mwp = 1; end
                    else mx = mx - STP;
                end else if (md == 2) my = (my - STP) & 1023;
                else my = (my + STP) & 1023;
                mac = mac + 1;
                if (mac == 4) begin mac = 0; mfr = (mfr + 1) % 4; end
            end else if (mst == 1) begin
                mst = 2;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = mx; e.y = my; e.d = md; e.mv = mmv; e.fl = mfl; e.fr = mfr; e.wp = mwp;
        q.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        if (q.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
        end else begin
            e = q.pop_front();
            check_eq("pos_x", int'(pos_x), e.x);
            check_eq("pos_y", int'(pos_y), e.y);
            check_eq("dir", int'(dir), e.d);
            check_eq("moving", int'(moving), e.mv);
            check_eq("facing_left", int'(facing_left), e.fl);
            check_eq("anim_frame", int'(anim_frame), e.fr);
            check_eq("wrap_pulse", int'(wrap_pulse), e.wp);
        end
    endtask

    task automatic do_cycle(input bit mt, input bit fz, input bit r, input bit l,
                            input bit u, input bit d, input logic [3:0] lg);
        move_tick = mt; freeze = fz;
        req_r = r; req_l = l; req_u = u; req_d = d; leg = lg;
        model_cycle(mt, fz, r, l, u, d, lg);
        push_exp();
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    initial begin
        int af[8];
        int xs_before;
        af = '{0, 0, 0, 1, 1, 1, 1, 2};

        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp();
        sb_compare();

        // first turn from IDLE, then persistent motion and animation cadence
        do_cycle(1, 0, 1, 0, 0, 0, 4'hF);
        check_eq("x_first", int'(pos_x), 362);
        check_eq("frame_t0", int'(anim_frame), af[0]);
        for (int i = 1; i < 8; i++) begin
            do_cycle(1, 0, 0, 0, 0, 0, 4'hF);
            check_eq("x_run", int'(pos_x), 362 + 2 * i);
            check_eq("frame_seq", int'(anim_frame), af[i]);
        end
        do_cycle(0, 0, 0, 0, 0, 0, 4'hF);

        // queued up-turn waits for legality
        do_cycle(1, 0, 0, 0, 1, 0, 4'h1);
        do_cycle(1, 0, 0, 0, 1, 0, 4'h1);
        check_eq("x_queued", int'(pos_x), 380);
        do_cycle(1, 0, 0, 0, 0, 0, 4'h5);
        check_eq("dir_up", int'(dir), 2);
        check_eq("y_up", int'(pos_y), 152);
        check_eq("x_hold_on_turn", int'(pos_x), 380);
        do_cycle(1, 0, 1, 0, 0, 0, 4'hF);

        // blocked then released
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 0, 0, 4'h0);
        check_eq("blocked_mv", int'(moving), 0);
        xs_before = int'(pos_x);
        do_cycle(1, 0, 0, 0, 0, 0, 4'h1);
        check_eq("unblock_x", int'(pos_x), xs_before + 2);

        // right tunnel wrap
        for (int i = 0; i < 130; i++) do_cycle(1, 0, 0, 0, 0, 0, 4'h1);
        do_cycle(0, 0, 0, 0, 0, 0, 4'h1);

        // simultaneous L+D: L wins
        do_cycle(1, 0, 0, 1, 0, 1, 4'hF);
        check_eq("dir_l_prio", int'(dir), 1);
        check_eq("facing_l", int'(facing_left), 1);
        for (int i = 0; i < 10; i++) do_cycle(1, 0, 0, 0, 0, 0, 4'h2);

        // requests during freeze are not latched
        for (int i = 0; i < 3; i++) do_cycle(1, 1, 0, 0, 1, 0, 4'hF);
        do_cycle(1, 0, 0, 0, 0, 0, 4'hF);
        check_eq("freeze_no_latch", int'(dir), 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     4'($urandom_range(0, 15)));
        end

        // asynchronous reset mid-cycle
        do_cycle(1, 0, 1, 0, 0, 0, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        sb_compare();
        #2 rst_n = 1'b1;
        do_cycle(1, 0, 0, 0, 0, 0, 4'hF);
        check_eq("idle_after_rst", int'(pos_x), 360);

        // odd start position exercises the exact boundary values
        o_req_r = 1'b1; o_tick = 1'b1;
        @(posedge clk); #1;
        check_eq("odd_wrap_x", int'(o_pos_x), 150);
        check_eq("odd_wrap_pulse", int'(o_wrap_pulse), 1);
        o_req_r = 1'b0; o_tick = 1'b0;
        @(posedge clk); #1;
        check_eq("odd_pulse_clear", int'(o_wrap_pulse), 0);
        check_eq("odd_x_hold", int'(o_pos_x), 150);
        o_req_l = 1'b1; o_tick = 1'b1;
        @(posedge clk); #1;
        check_eq("odd_lwrap_x", int'(o_pos_x), 600);
        check_eq("odd_lwrap_pulse", int'(o_wrap_pulse), 1);
        check_eq("odd_facing", int'(o_facing_left), 1);
        o_req_l = 1'b0; o_tick = 1'b0;

        if (q.size() != 0) check_eq("sb_leftover", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
